// File: rtl/vec_mem_mover_if.sv
// vec_mem_mover_if
// Bundles the data-memory bus and the vector register file ports used by
// vec_mem_mover.
//   master : the mover (drives requests, vector read address, vector write)
//   slave  : memory / vector RAM side
// Memory : o_mem_addr/o_mem_read/o_mem_write/o_mem_wdata out, i_mem_ready/i_mem_rdata in
// Vector : o_vec_read_addr out, i_vec_read_data in, o_vec_write_* out
interface vec_mem_mover_if #(
    parameter int VEC_SIZE        = 8,
    parameter int VEC_INDEX_WIDTH = 3,
    parameter int ADDR_WIDTH      = 16
);
    logic [ADDR_WIDTH-1:0]           o_mem_addr;
    logic                            o_mem_read;
    logic                            o_mem_write;
    logic [VEC_SIZE-1:0]             o_mem_wdata;
    logic                            i_mem_ready;
    logic [VEC_SIZE-1:0]             i_mem_rdata;
    logic [VEC_INDEX_WIDTH-1:0]      o_vec_read_addr;
    logic [15:0][VEC_SIZE-1:0]       i_vec_read_data;
    logic                            o_vec_write_enable;
    logic [VEC_INDEX_WIDTH-1:0]      o_vec_write_addr;
    logic [15:0][VEC_SIZE-1:0]       o_vec_write_data;

    modport master (
        output o_mem_addr, o_mem_read, o_mem_write, o_mem_wdata,
        input  i_mem_ready, i_mem_rdata,
        output o_vec_read_addr,
        input  i_vec_read_data,
        output o_vec_write_enable, o_vec_write_addr, o_vec_write_data
    );

    modport slave (
        input  o_mem_addr, o_mem_read, o_mem_write, o_mem_wdata,
        output i_mem_ready, i_mem_rdata,
        input  o_vec_read_addr,
        output i_vec_read_data,
        input  o_vec_write_enable, o_vec_write_addr, o_vec_write_data
    );
endinterface

// File: rtl/vec_mem_mover.sv
// vec_mem_mover
// Sequential mover between scalar data memory and the vector register file.
// Load: gathers 16 strided lanes from memory, then writes the vector in one cycle.
// Store: reads one vector, then scatters its 16 lanes to strided addresses.
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_start, i_store, i_base_addr, i_stride, i_vec_idx : command, taken in IDLE
//   o_busy : high outside IDLE;  o_done : registered one-cycle completion pulse
//   bus    : memory bus + vector RAM ports (vec_mem_mover_if.master)
module vec_mem_mover #(
    parameter int VEC_SIZE        = 8,
    parameter int VEC_INDEX_WIDTH = 3,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_store,
    input  logic [ADDR_WIDTH-1:0]      i_base_addr,
    input  logic [ADDR_WIDTH-1:0]      i_stride,
    input  logic [VEC_INDEX_WIDTH-1:0] i_vec_idx,
    output logic                       o_busy,
    output logic                       o_done,
    vec_mem_mover_if.master            bus
);
    localparam int NUM_LANES = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LWRITE, S_SREAD, S_STORE
    } state_t;

    state_t                              r_state, w_next;
    logic [ADDR_WIDTH-1:0]               r_addr;
    logic [ADDR_WIDTH-1:0]               r_stride;
    logic [VEC_INDEX_WIDTH-1:0]          r_idx;
    logic [3:0]                          r_cnt;
    logic                                r_done;
    logic [NUM_LANES-1:0][VEC_SIZE-1:0]  w_buf;

    logic w_mem_read, w_mem_write, w_vec_we;
    logic w_accept, w_last, w_take;

    assign w_take   = (r_state == S_IDLE) && i_start;
    assign w_accept = (w_mem_read | w_mem_write) & bus.i_mem_ready;
    assign w_last   = (r_cnt == 4'(NUM_LANES - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_vec_we    = 1'b0;
        case (r_state)
            S_IDLE:   if (i_start) w_next = i_store ? S_SREAD : S_LOAD;
            S_LOAD: begin
                w_mem_read = 1'b1;
                if (bus.i_mem_ready && w_last) w_next = S_LWRITE;
            end
            S_LWRITE: begin
                w_vec_we = 1'b1;
                w_next   = S_IDLE;
            end
            // Vector RAM samples the address on the falling edge, so the
            // data is ready to capture on the edge that ends this cycle.
            S_SREAD:  w_next = S_STORE;
            S_STORE: begin
                w_mem_write = 1'b1;
                if (bus.i_mem_ready && w_last) w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- address / counter / command latch ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_addr   <= '0;
            r_stride <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_LWRITE) ||
                      ((r_state == S_STORE) && bus.i_mem_ready && w_last);
            if (w_take) begin
                r_addr   <= i_base_addr;
                r_stride <= i_stride;
                r_idx    <= i_vec_idx;
                r_cnt    <= '0;
            end else if (w_accept) begin
                r_addr <= r_addr + r_stride;   // wraps mod 2^ADDR_WIDTH
                r_cnt  <= r_cnt + 4'd1;
            end
        end
    end

    // ---------------- lane buffer ----------------
    // Each lane fills either from its own memory beat (load) or all at once
    // from the vector RAM (store).
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [VEC_SIZE-1:0] r_lane;
        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst)
                r_lane <= '0;
            else if (r_state == S_SREAD)
                r_lane <= bus.i_vec_read_data[l];
            else if ((r_state == S_LOAD) && bus.i_mem_ready && (r_cnt == 4'(l)))
                r_lane <= bus.i_mem_rdata;
        end
        assign w_buf[l] = r_lane;
    end

    // ---------------- outputs ----------------
    assign o_busy                 = (r_state != S_IDLE);
    assign o_done                 = r_done;
    assign bus.o_mem_addr         = r_addr;
    assign bus.o_mem_read         = w_mem_read;
    assign bus.o_mem_write        = w_mem_write;
    assign bus.o_mem_wdata        = w_buf[r_cnt];
    assign bus.o_vec_read_addr    = r_idx;
    assign bus.o_vec_write_enable = w_vec_we;
    assign bus.o_vec_write_addr   = r_idx;
    assign bus.o_vec_write_data   = w_buf;
endmodule

// File: tb/tb_vec_mem_mover.sv
// tb_vec_mem_mover
// Directed + randomized bench for vec_mem_mover. A flat memory array and a
// vector RAM array act as both the environment and the reference model:
// expected addresses are base + n*stride, expected lane data come from the
// model arrays, expected completion cycles follow from when the 16th lane
// is accepted.
module tb_vec_mem_mover;
    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start, i_store;
    logic [15:0] i_base_addr, i_stride;
    logic [2:0]  i_vec_idx;
    logic        o_busy, o_done;

    vec_mem_mover_if #(.VEC_SIZE(8), .VEC_INDEX_WIDTH(3), .ADDR_WIDTH(16)) bus ();

    vec_mem_mover #(.VEC_SIZE(8), .VEC_INDEX_WIDTH(3), .ADDR_WIDTH(16)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_store(i_store),
        .i_base_addr(i_base_addr), .i_stride(i_stride), .i_vec_idx(i_vec_idx),
        .o_busy(o_busy), .o_done(o_done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0]       mem  [0:65535];
    logic [15:0][7:0] vram [0:7];
    int               n_assert = 0;
    int               n_fail   = 0;
    int               vwr_cnt  = 0;

    assign bus.i_mem_rdata = mem[bus.o_mem_addr];

    // Vector RAM registers its read address on the falling edge.
    always @(negedge clk) bus.i_vec_read_data <= vram[bus.o_vec_read_addr];

    always @(posedge clk) if (bus.o_vec_write_enable) vwr_cnt <= vwr_cnt + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            bus.i_mem_ready = 1'b0;
            @(negedge clk);
            chk("idle_busy", o_busy, 1'b0);
            chk("idle_done", o_done, 1'b0);
        end
    endtask

    // Issues one command (start driven now, taken on the next edge) and
    // checks every cycle until the expected o_done. Returns at the negedge
    // of the done cycle, so a following call starts in the done cycle.
    task automatic run_op(input bit st, input logic [15:0] base, input logic [15:0] stride,
                          input logic [2:0] idx, input int mode, input int bs_cycle,
                          input int exp_done_fixed);
        logic [15:0][7:0] src, expv;
        logic [15:0]      ea;
        int c = 0, n = 0, last = 0, dcyc = 0, wr0;
        bit fin = 0, rdy, exp_req, exp_we;
        src = vram[idx];
        expv = '0;
        wr0 = vwr_cnt;
        i_start = 1'b1; i_store = st; i_base_addr = base; i_stride = stride; i_vec_idx = idx;
        while (!fin) begin
            @(posedge clk); #1;
            c++;
            i_start = (c == bs_cycle);
            if (c == bs_cycle) begin
                i_store = ~st; i_vec_idx = idx + 3'd1; i_base_addr = ~base;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 2) == 1;
                default: rdy = ($urandom % 4) != 0;
            endcase
            bus.i_mem_ready = rdy;
            @(negedge clk);
            exp_req = (n < 16) && (st ? (c >= 2) : 1'b1);
            chk("mem_read", bus.o_mem_read, !st && exp_req);
            chk("mem_write", bus.o_mem_write, st && exp_req);
            if (exp_req) begin
                ea = base + stride * 16'(n);
                chk("mem_addr", bus.o_mem_addr, ea);
                if (st) begin
                    chk("mem_wdata", bus.o_mem_wdata, src[n]);
                    if (rdy) mem[ea] = src[n];
                end else begin
                    expv[n] = mem[ea];
                end
                if (rdy) begin n++; last = c; end
            end
            dcyc = st ? last + 1 : last + 2;
            exp_we = !st && (n == 16) && (c == last + 1);
            chk("vec_we", bus.o_vec_write_enable, exp_we);
            if (exp_we) begin
                chk("vec_waddr", bus.o_vec_write_addr, idx);
                chk("vec_wdata", bus.o_vec_write_data, expv);
                vram[idx] = expv;
            end
            chk("done", o_done, (n == 16) && (c == dcyc));
            chk("busy", o_busy, !((n == 16) && (c >= dcyc)));
            if ((n == 16) && (c == dcyc)) fin = 1;
            else if (c > 300) begin
                chk("op_timeout_done", o_done, 1'b1);
                fin = 1;
            end
        end
        if (exp_done_fixed >= 0) chk("done_cycle", c, exp_done_fixed);
        chk("vec_write_count", vwr_cnt - wr0, st ? 0 : 1);
        chk("vec_read_addr", bus.o_vec_read_addr, idx);
    endtask

    initial begin
        logic [2:0]  ridx;
        logic [15:0] rbase, rstride;
        bit          rst_;
        int          wr_before;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int v = 0; v < 8; v++) vram[v] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++) begin
            mem[16'h0100 + i] = 8'(8'h10 + i);
            vram[2][i]        = 8'(8'hA0 + i);
        end
        i_rst = 1'b0; i_start = 1'b0; i_store = 1'b0;
        i_base_addr = '0; i_stride = '0; i_vec_idx = '0;
        bus.i_mem_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_mem_rw", {bus.o_mem_read, bus.o_mem_write, bus.o_vec_write_enable}, 3'b000);
        chk("rst_mem_addr", bus.o_mem_addr, 16'h0);
        chk("rst_mem_wdata", bus.o_mem_wdata, 8'h0);
        chk("rst_vec_addrs", {bus.o_vec_read_addr, bus.o_vec_write_addr}, 6'h0);
        chk("rst_vec_wdata", bus.o_vec_write_data, 128'h0);
        i_rst = 1'b1;
        idle(2);

        // Load plan case, then store plan case
        run_op(0, 16'h0100, 16'h0001, 3'd5, 0, -1, 18);
        idle(2);
        run_op(1, 16'h0200, 16'h0004, 3'd2, 0, -1, 18);
        idle(1);
        // Backpressure: ready low every other cycle
        run_op(0, 16'h0100, 16'h0001, 3'd3, 1, -1, 33);
        idle(1);
        // Wrap-around, then stride 0 store started in the done cycle
        run_op(0, 16'hFFFE, 16'h0001, 3'd1, 0, -1, 18);
        chk("done_before_chain", o_done, 1'b1);
        run_op(1, 16'h0040, 16'h0000, 3'd1, 0, -1, 18);
        idle(1);
        // Start while busy is ignored
        run_op(0, 16'h0500, 16'h0002, 3'd4, 0, 5, 18);
        idle(2);

        // Async reset in cycle 8 of a load
        wr_before = vwr_cnt;
        i_start = 1'b1; i_store = 1'b0; i_base_addr = 16'h0300; i_stride = 16'h0003; i_vec_idx = 3'd6;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            bus.i_mem_ready = 1'b1;
        end
        i_rst = 1'b0;
        #1;
        chk("arst_busy", o_busy, 1'b0);
        chk("arst_strobes", {bus.o_mem_read, bus.o_mem_write, bus.o_vec_write_enable, o_done}, 4'b0000);
        chk("arst_mem_addr", bus.o_mem_addr, 16'h0);
        chk("arst_vec_addr", bus.o_vec_read_addr, 3'd0);
        chk("arst_vec_wdata", bus.o_vec_write_data, 128'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("arst_hold_we_done", {bus.o_vec_write_enable, o_done}, 2'b00);
        end
        i_rst = 1'b1;
        idle(2);
        chk("arst_no_vec_write", vwr_cnt - wr_before, 0);
        run_op(0, 16'h0300, 16'h0003, 3'd6, 0, -1, 18);
        idle(1);

        // Randomized commands with random ready
        for (int r = 0; r < 5; r++) begin
            rst_    = 1'($urandom);
            ridx    = 3'($urandom);
            rbase   = 16'($urandom);
            rstride = 16'($urandom_range(0, 40));
            run_op(rst_, rbase, rstride, ridx, 2, -1, -1);
            idle(1);
        end
        // Scatter a previously loaded vector back out to confirm its contents
        run_op(1, 16'h7000, 16'h0001, 3'd5, 2, -1, -1);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_mem_mover.md
# vec_mem_mover

Sequential DMA-style mover between scalar data memory and the vector register file RAM. A load gathers 16 lanes from strided memory addresses and writes the assembled vector through the vector RAM write port. A store reads one vector through a vector RAM read port and scatters its 16 lanes to strided memory addresses. Sits beside the vector register file, driving its write port and one of its read ports, and acts as master on the data-memory bus.

## Interface
- VEC_SIZE, 8: lane width in bits; vectors are 16 lanes.
- VEC_INDEX_WIDTH, 3: vector register index width.
- ADDR_WIDTH, 16: data-memory address width.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset; asynchronous, active-low.
- i_start  in  1  command strobe, sampled only in IDLE.
- i_store  in  1  0 = load (mem→vec), 1 = store (vec→mem); sampled with i_start.
- i_base_addr  in  ADDR_WIDTH  address of lane 0.
- i_stride  in  ADDR_WIDTH  address increment per lane.
- i_vec_idx  in  VEC_INDEX_WIDTH  destination (load) or source (store) vector.
- o_busy  out  1  high in every non-IDLE state.
- o_done  out  1  one-cycle completion pulse.
- o_mem_addr  out  ADDR_WIDTH  memory request address.
- o_mem_read  out  1  read request.
- o_mem_write  out  1  write request.
- o_mem_wdata  out  VEC_SIZE  store lane data.
- i_mem_ready  in  1  request accepted this cycle; read data valid in the same cycle.
- i_mem_rdata  in  VEC_SIZE  load lane data.
- o_vec_read_addr  out  VEC_INDEX_WIDTH  vector RAM read address.
- i_vec_read_data  in  16×VEC_SIZE  vector RAM read data.
- o_vec_write_enable  out  1  vector RAM write strobe.
- o_vec_write_addr  out  VEC_INDEX_WIDTH  vector RAM write address.
- o_vec_write_data  out  16×VEC_SIZE  vector RAM write data.

## Operation
- States: IDLE, LOAD, LWRITE, SREAD, STORE.
- IDLE: on i_start, latch base, stride, idx, direction; clear lane counter to 0 and the address register to base; go to LOAD (i_store=0) or SREAD (i_store=1). i_start outside IDLE is ignored.
- LOAD: hold o_mem_read=1 and o_mem_addr=current address until i_mem_ready. On accept, write i_mem_rdata into buffer lane[counter], add stride to address (mod 2^ADDR_WIDTH), and increment counter. On accepting lane 15, go to LWRITE.
- LWRITE: o_vec_write_enable=1 for exactly one cycle with buffer and latched idx; go to IDLE.
- SREAD: o_vec_read_addr = latched idx. The vector RAM registers the read address on the falling edge, so data is valid by the rising edge that ends this cycle. Capture i_vec_read_data into the buffer; go to STORE.
- STORE: hold o_mem_write=1, o_mem_addr, and o_mem_wdata=buffer lane[counter] until i_mem_ready. On accept, advance address and counter. After lane 15 is accepted, go to IDLE.
- o_done is a registered signal. It is 1 in the first IDLE cycle after LWRITE or the final STORE accept, and 0 otherwise.
- Lane address = base + i·stride, truncated to ADDR_WIDTH (wrap-around allowed). Stride 0 addresses the same location for all 16 lanes.
- Request outputs stay stable while waiting for ready. o_mem_read and o_mem_write are never high together.
- o_vec_read_addr continuously drives the latched idx register (0 after reset).

## Timing
- Reset values: state IDLE; o_busy, o_done, o_mem_read, o_mem_write, o_vec_write_enable = 0. o_mem_addr, o_mem_wdata, o_vec_read_addr, o_vec_write_addr, o_vec_write_data, buffer, counter = 0.
- Load with ready held high: start sampled at edge 0; lane k requested in cycle k+1 (cycles 1–16); write in cycle 17; o_done in cycle 18. Each low-ready cycle adds one cycle.
- Store with ready held high: SREAD in cycle 1; lanes in cycles 2–17; o_done in cycle 18.
- i_start may be asserted in the same cycle o_done is high; that start is accepted.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No vector write is issued. Memory writes already accepted stay performed. No o_done pulse.

## Test plan
- Load: base 0x0100, stride 1, idx 5, memory[0x100+i] = i+0x10, ready always 1 → 16 reads at 0x100..0x10F in cycles 1–16; write to vec 5 with lane i = 0x10+i in cycle 17; o_done in cycle 18.
- Store: vec 2 holds lane i = 0xA0+i, base 0x0200, stride 4 → writes 0xA0+i to 0x200+4i in cycles 2–17; o_done in cycle 18.
- Backpressure: load with i_mem_ready low on every other cycle → addresses and lanes unchanged, completion in cycle 33, request outputs stable while stalled.
- Wrap and stride 0: base 0xFFFE, stride 1 → lane 2 at 0x0000. Stride 0 → all 16 requests to the base address.
- Start while busy: second i_start in cycle 5 → ignored, one write only. Start in the o_done cycle → accepted, o_busy high next cycle.
- Async reset in cycle 8 of a load → outputs reset at once, no o_vec_write_enable, no o_done. A new load after reset completes normally.
